// File: rtl/func_identifier.sv
`default_nettype none
// ============================================================================
// Module   : func_identifier
// Purpose  : Drives a/b through all four combinations into a 2-input function
//            unit, captures the response and decodes it back to the select code
//            (00=OR, 01=NOR, 10=XOR, 11=XNOR). FUNC_ID_RETRY_EN adds one silent
//            re-probe after an unrecognised truth vector.
// Revision : 1.0 - initial release
// ============================================================================
module func_identifier #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s_in,
    output logic       probe_a,
    output logic       probe_b,
    output logic       busy,
    output logic       done,
    output logic [1:0] op_code,
    output logic       valid,
    output logic       error
);

    localparam logic [3:0] c_vec_or    = 4'b1110;
    localparam logic [3:0] c_vec_nor   = 4'b0001;
    localparam logic [3:0] c_vec_xor   = 4'b0110;
    localparam logic [3:0] c_vec_xnor  = 4'b1001;
    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROBE  = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic [3:0] r_vec;
    logic       w_match;
    logic [1:0] w_op;
`ifdef FUNC_ID_RETRY_EN
    logic       r_retry_pend;
    logic       r_retried;
`endif

    always_comb begin
        w_match = 1'b1;
        w_op    = 2'b00;
        case (r_vec)
            c_vec_or:   w_op = 2'b00;
            c_vec_nor:  w_op = 2'b01;
            c_vec_xor:  w_op = 2'b10;
            c_vec_xnor: w_op = 2'b11;
            default:    w_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_vec   <= 4'd0;
            probe_a <= 1'b0;
            probe_b <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            op_code <= 2'b00;
            valid   <= 1'b0;
            error   <= 1'b0;
`ifdef FUNC_ID_RETRY_EN
            r_retry_pend <= 1'b0;
            r_retried    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef FUNC_ID_RETRY_EN
                    // A pending retry behaves like an internally issued start.
                    if (r_retry_pend) begin
                        r_retry_pend <= 1'b0;
                        r_state      <= S_PROBE;
                        r_idx        <= 2'd0;
                        r_cnt        <= 4'd0;
                        r_vec        <= 4'd0;
                        probe_a      <= 1'b0;
                        probe_b      <= 1'b0;
                    end else
`endif
                    if (start) begin
                        r_state <= S_PROBE;
                        r_idx   <= 2'd0;
                        r_cnt   <= 4'd0;
                        r_vec   <= 4'd0;
                        probe_a <= 1'b0;
                        probe_b <= 1'b0;
                        busy    <= 1'b1;
                        op_code <= 2'b00;
                        valid   <= 1'b0;
                        error   <= 1'b0;
`ifdef FUNC_ID_RETRY_EN
                        r_retried <= 1'b0;
`endif
                    end
                end
                S_PROBE: begin
                    if (r_cnt == c_settle_last) begin
                        r_cnt        <= 4'd0;
                        r_vec[r_idx] <= s_in;
                        if (r_idx == 2'd3) begin
                            r_state <= S_DECODE;
                            probe_a <= 1'b0;
                            probe_b <= 1'b0;
                        end else begin
                            r_idx              <= r_idx + 2'd1;
                            {probe_a, probe_b} <= r_idx + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DECODE: begin
`ifdef FUNC_ID_RETRY_EN
                    if (!w_match && !r_retried) begin
                        r_retried    <= 1'b1;
                        r_retry_pend <= 1'b1;
                        r_state      <= S_IDLE;
                    end else
`endif
                    begin
                        r_state <= S_IDLE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        valid   <= w_match;
                        error   <= ~w_match;
                        op_code <= w_op;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_func_identifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_func_identifier
// Purpose  : Randomised self-checking bench; instance 0 uses SETTLE=1,
//            instance 1 uses SETTLE=3, each driving its own function-unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_func_identifier;

`ifdef FUNC_ID_RETRY_EN
    localparam bit c_retry = 1'b1;
`else
    localparam bit c_retry = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v  [2];
    logic       tb_clr   [2];
    logic [3:0] tbl1     [2];
    logic [3:0] tbl2     [2];
    logic       pa       [2];
    logic       pb       [2];
    logic       busy_v   [2];
    logic       done_v   [2];
    logic [1:0] opc      [2];
    logic       valid_v  [2];
    logic       error_v  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int c_s = (k == 0) ? 1 : 3;
        logic       seen3;
        logic       pass_sel;
        logic [3:0] cur;
        logic       s_in_w;

        // Unit model: first-pass table until a full probe pass completes, then the second.
        assign cur    = pass_sel ? tbl2[k] : tbl1[k];
        assign s_in_w = cur[{pa[k], pb[k]}];

        always @(posedge clk) begin
            if (tb_clr[k]) begin
                seen3    <= 1'b0;
                pass_sel <= 1'b0;
            end else begin
                if ({pa[k], pb[k]} == 2'b11) seen3 <= 1'b1;
                if (seen3 && {pa[k], pb[k]} == 2'b00) pass_sel <= 1'b1;
            end
        end

        func_identifier #(.SETTLE(c_s)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start_v[k]),
            .s_in    (s_in_w),
            .probe_a (pa[k]),
            .probe_b (pb[k]),
            .busy    (busy_v[k]),
            .done    (done_v[k]),
            .op_code (opc[k]),
            .valid   (valid_v[k]),
            .error   (error_v[k])
        );
    end

    // Truth vector of a select code: bit i is f(a,b) with {a,b}=i.
    function automatic logic [3:0] truth(input logic [1:0] op);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            case (op)
                2'd0: v[i] = ab[1] | ab[0];
                2'd1: v[i] = ~(ab[1] | ab[0]);
                2'd2: v[i] = ab[1] ^ ab[0];
                default: v[i] = ~(ab[1] ^ ab[0]);
            endcase
        end
        return v;
    endfunction

    function automatic bit lookup(input logic [3:0] v, output logic [1:0] op);
        op = 2'b00;
        for (int o = 0; o < 4; o++) begin
            if (truth(2'(o)) == v) begin
                op = 2'(o);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic prep(input int k, input logic [3:0] t1, input logic [3:0] t2);
        tbl1[k] = t1;
        tbl2[k] = t2;
        @(negedge clk) tb_clr[k] = 1'b1;
        @(negedge clk) tb_clr[k] = 1'b0;
    endtask

    task automatic run_case(input int k, input logic [3:0] t1, input logic [3:0] t2,
                            input bit pulse_mid, input string name);
        int         s;
        int         exp_n;
        bit         ok1, ok2, exp_valid, got;
        logic [1:0] op1, op2, exp_op;
        s   = (k == 0) ? 1 : 3;
        ok1 = lookup(t1, op1);
        ok2 = lookup(t2, op2);
        if (ok1 || !c_retry) begin
            exp_n = 4 * s + 1; exp_valid = ok1; exp_op = ok1 ? op1 : 2'b00;
        end else begin
            exp_n = 8 * s + 3; exp_valid = ok2; exp_op = ok2 ? op2 : 2'b00;
        end
        prep(k, t1, t2);
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            start_v[k] = 1'b0;
            checks++;
            if (done_v[k]) begin
                got = 1'b1;
                if (n !== exp_n) begin
                    errors++;
                    $display("FAIL %s latency: done after edge %0d, required %0d", name, n, exp_n);
                end
                checks++;
                if (busy_v[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_at_done: got %b required 0", name, busy_v[k]);
                end
            end else begin
                if (busy_v[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: edge %0d got %b required 1", name, n, busy_v[k]);
                end
                if (n < 4 * s) begin
                    checks++;
                    if ({pa[k], pb[k]} !== 2'(n / s)) begin
                        errors++;
                        $display("FAIL %s probe: edge %0d got %b required %b",
                                 name, n, {pa[k], pb[k]}, 2'(n / s));
                    end
                end
            end
            if (pulse_mid && n == 2) start_v[k] = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within 60 cycles, required at edge %0d", name, exp_n);
        end
        checks++;
        if ({opc[k], valid_v[k], error_v[k]} !== {exp_op, exp_valid, ~exp_valid}) begin
            errors++;
            $display("FAIL %s result: op/valid/error got %b/%b/%b required %b/%b/%b", name,
                     opc[k], valid_v[k], error_v[k], exp_op, exp_valid, ~exp_valid);
        end
        for (int n = 0; n < (pulse_mid ? 8 : 1); n++) begin
            @(posedge clk); #1;
            checks++;
            if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done: done/busy got %b/%b required 0/0",
                         name, done_v[k], busy_v[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({pa[k], pb[k], busy_v[k], done_v[k], opc[k], valid_v[k], error_v[k]} !== 8'd0) begin
                errors++;
                $display("FAIL reset inst%0d: outputs got %b required 00000000", k,
                         {pa[k], pb[k], busy_v[k], done_v[k], opc[k], valid_v[k], error_v[k]});
            end
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        prep(0, truth(2'd2), truth(2'd2));
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pa[0], pb[0]} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid probe_idx2: got %b required 10", {pa[0], pb[0]});
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({pa[0], pb[0], busy_v[0], done_v[0], opc[0], valid_v[0], error_v[0]} !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %b required 00000000",
                     {pa[0], pb[0], busy_v[0], done_v[0], opc[0], valid_v[0], error_v[0]});
        end
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            checks++;
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid aborted: done/busy got %b/%b required 0/0", done_v[0], busy_v[0]);
            end
        end
        run_case(0, truth(2'd2), truth(2'd2), 1'b0, "reset_mid_xor");
    endtask

    task automatic test_back_to_back();
        bit got;
        prep(0, truth(2'd0), truth(2'd0));
        start_v[0] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(posedge clk); #1;
            if (done_v[0]) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b first_done: timeout, required done within 30 cycles");
        end
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        checks++;
        if ({busy_v[0], valid_v[0], error_v[0]} !== 3'b100) begin
            errors++;
            $display("FAIL b2b restart: busy/valid/error got %b required 100",
                     {busy_v[0], valid_v[0], error_v[0]});
        end
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (done_v[0]) begin
                got = 1'b1;
                checks++;
                if (n !== 5) begin
                    errors++;
                    $display("FAIL b2b latency: got edge %0d required 5", n);
                end
            end
        end
        checks++;
        if (!got || {opc[0], valid_v[0], error_v[0]} !== 4'b0010) begin
            errors++;
            $display("FAIL b2b second: got done=%b op/valid/error %b required done=1 0010",
                     got, {opc[0], valid_v[0], error_v[0]});
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int         k;
            logic [3:0] t1, t2;
            k  = int'($urandom_range(0, 1));
            t1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : truth(2'($urandom));
            t2 = ($urandom_range(0, 1) == 0) ? 4'($urandom) : truth(2'($urandom));
            run_case(k, t1, t2, 1'b0, "random");
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b0;
            tb_clr[k]  = 1'b1;
            tbl1[k]    = 4'd0;
            tbl2[k]    = 4'd0;
        end
        test_reset();
        run_case(0, truth(2'd0), truth(2'd0), 1'b0, "or_s1");
        run_case(1, truth(2'd3), truth(2'd3), 1'b0, "xnor_s3");
        run_case(0, 4'b0000, 4'b0000, 1'b0, "stuck0");
        run_case(1, 4'b1111, 4'b1111, 1'b0, "stuck1_s3");
        run_case(0, truth(2'd1), truth(2'd1), 1'b1, "nor_busy_start");
        test_reset_mid();
        run_case(0, truth(2'd2) ^ 4'b0010, truth(2'd2), 1'b0, "glitch_xor");
        run_case(1, truth(2'd2) ^ 4'b0010, truth(2'd2), 1'b0, "glitch_xor_s3");
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
